// File: rtl/vec_buf_pkg.sv
// Shared types and sizing helpers for the vector stream buffer.
package vec_buf_pkg;

    typedef logic [7:0] byte_t;

    // Number of beats needed to move elems bytes at per bytes per beat.
    function automatic int chunks(int elems, int per);
        return elems / per;
    endfunction

    // Pointer width for n distinct values; never narrower than one bit.
    function automatic int ptr_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_buf_mem.sv
// Byte-addressed simple dual-port storage: multi-lane write, registered multi-lane read.
module vec_buf_mem
    import vec_buf_pkg::*;
#(
    parameter int unsigned Size          = 16,
    parameter int unsigned BytesPerWrite = 1,
    parameter int unsigned BytesPerRead  = 2,
    parameter int unsigned AddrW         = 4
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           we,
    input  logic [AddrW-1:0]               waddr,
    input  logic [BytesPerWrite-1:0][7:0]  wdata,
    input  logic                           re,
    input  logic [AddrW-1:0]               raddr,
    output logic [BytesPerRead-1:0][7:0]   rdata
);

    byte_t mem [Size];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk_in) begin
        if (we) begin
            for (int i = 0; i < int'(BytesPerWrite); i++) begin
                mem[waddr + AddrW'(i)] <= wdata[i];
            end
        end
    end

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rdata <= '0;
        end else if (re) begin
            for (int i = 0; i < int'(BytesPerRead); i++) begin
                rdata[i] <= mem[raddr + AddrW'(i)];
            end
        end
    end

endmodule

// File: rtl/vec_stream_buffer.sv
// Multi-vector stream buffer: producer fills whole vectors, consumer re-reads and pops the head.
module vec_stream_buffer
    import vec_buf_pkg::*;
#(
    parameter int unsigned VecElements   = 8,
    parameter int unsigned BytesPerWrite = 1,
    parameter int unsigned BytesPerRead  = 2,
    parameter int unsigned Depth         = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            wr_en,
    input  logic [BytesPerWrite-1:0][7:0]   wr_data,
    input  logic                            rd_en,
    output logic [BytesPerRead-1:0][7:0]    rd_data,
    output logic                            rd_valid,
    output logic                            rd_last,
    input  logic                            wrap_rd,
    input  logic                            pop_vec,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(Depth+1)-1:0]      vec_count
);

    localparam int unsigned WrChunks = chunks(VecElements, BytesPerWrite);
    localparam int unsigned RdChunks = chunks(VecElements, BytesPerRead);
    localparam int unsigned Size     = Depth * VecElements;
    localparam int unsigned VW       = ptr_w(Depth);
    localparam int unsigned WCW      = ptr_w(WrChunks);
    localparam int unsigned RCW      = ptr_w(RdChunks);
    localparam int unsigned AW       = ptr_w(Size);
    localparam int unsigned CW       = $clog2(Depth + 1);

    if (VecElements % BytesPerWrite != 0) begin : g_chk_wr
        $error("VecElements must be a multiple of BytesPerWrite");
    end
    if (VecElements % BytesPerRead != 0) begin : g_chk_rd
        $error("VecElements must be a multiple of BytesPerRead");
    end
    if (Depth < 1) begin : g_chk_depth
        $error("Depth must be at least 1");
    end

    logic [VW-1:0]  wr_vec_q, wr_vec_d, rd_vec_q, rd_vec_d;
    logic [WCW-1:0] wr_chunk_q, wr_chunk_d;
    logic [RCW-1:0] rd_chunk_q, rd_chunk_d;
    logic [CW-1:0]  count_q, count_d;
    logic           rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic           wr_acc, commit, pop_acc, rd_acc;
    logic [AW-1:0]  wr_addr, rd_addr;

    // Flags come purely from the registered count.
    assign full      = (count_q == CW'(Depth));
    assign empty     = (count_q == '0);
    assign vec_count = count_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;

    assign wr_acc  = wr_en && !full;
    assign commit  = wr_acc && (wr_chunk_q == WCW'(WrChunks - 1));
    assign pop_acc = pop_vec && !empty;
    assign rd_acc  = rd_en && !empty && !wrap_rd && !pop_vec;

    assign wr_addr = AW'(wr_vec_q) * AW'(VecElements) + AW'(wr_chunk_q) * AW'(BytesPerWrite);
    assign rd_addr = AW'(rd_vec_q) * AW'(VecElements) + AW'(rd_chunk_q) * AW'(BytesPerRead);

    // Next-state for pointers, count and read qualifiers; pop beats wrap beats read.
    always_comb begin
        wr_vec_d   = wr_vec_q;
        wr_chunk_d = wr_chunk_q;
        rd_vec_d   = rd_vec_q;
        rd_chunk_d = rd_chunk_q;
        count_d    = count_q;
        rd_valid_d = rd_acc;
        rd_last_d  = rd_last_q;

        if (wr_acc) begin
            if (commit) begin
                wr_chunk_d = '0;
                wr_vec_d   = (wr_vec_q == VW'(Depth - 1)) ? '0 : wr_vec_q + VW'(1);
            end else begin
                wr_chunk_d = wr_chunk_q + WCW'(1);
            end
        end

        if (pop_acc) begin
            rd_vec_d   = (rd_vec_q == VW'(Depth - 1)) ? '0 : rd_vec_q + VW'(1);
            rd_chunk_d = '0;
        end else if (wrap_rd) begin
            rd_chunk_d = '0;
        end else if (rd_acc) begin
            rd_last_d  = (rd_chunk_q == RCW'(RdChunks - 1));
            rd_chunk_d = rd_last_d ? '0 : rd_chunk_q + RCW'(1);
        end

        if (commit && !pop_acc) begin
            count_d = count_q + CW'(1);
        end else if (pop_acc && !commit) begin
            count_d = count_q - CW'(1);
        end
    end

    // State register; reset discards any partially written vector.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_vec_q   <= '0;
            wr_chunk_q <= '0;
            rd_vec_q   <= '0;
            rd_chunk_q <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            wr_vec_q   <= wr_vec_d;
            wr_chunk_q <= wr_chunk_d;
            rd_vec_q   <= rd_vec_d;
            rd_chunk_q <= rd_chunk_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    vec_buf_mem #(
        .Size          (Size),
        .BytesPerWrite (BytesPerWrite),
        .BytesPerRead  (BytesPerRead),
        .AddrW         (AW)
    ) u_mem (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .we     (wr_acc),
        .waddr  (wr_addr),
        .wdata  (wr_data),
        .re     (rd_acc),
        .raddr  (rd_addr),
        .rdata  (rd_data)
    );

endmodule

// File: tb/tb_vec_stream_buffer.sv
// Directed table-driven bench for vec_stream_buffer (8 bytes/vector, W=1, R=2, Depth=2).
module tb_vec_stream_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0, wrap_rd = 1'b0, pop_vec = 1'b0;
    logic [0:0][7:0] wr_data = '0;
    logic [1:0][7:0] rd_data;
    logic        rd_valid, rd_last, full, empty;
    logic [1:0]  vec_count;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       wr;
        logic       pv;
        logic       ev;
        logic [15:0] ed;
        logic       el;
        logic       ef;
        logic       ee;
        logic [1:0] ec;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    always #5 clk_in = ~clk_in;

    vec_stream_buffer #(
        .VecElements   (8),
        .BytesPerWrite (1),
        .BytesPerRead  (2),
        .Depth         (2)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .wrap_rd   (wrap_rd),
        .pop_vec   (pop_vec),
        .full      (full),
        .empty     (empty),
        .vec_count (vec_count)
    );

    function automatic vec_t row(logic we, logic [7:0] wd, logic re, logic wr, logic pv,
                                 logic ev, logic [15:0] ed, logic el, logic ef, logic ee,
                                 logic [1:0] ec);
        vec_t r;
        r.we = we; r.wd = wd; r.re = re; r.wr = wr; r.pv = pv;
        r.ev = ev; r.ed = ed; r.el = el; r.ef = ef; r.ee = ee; r.ec = ec;
        return r;
    endfunction

    // Drive one row, let one edge pass, then compare away from the edge.
    task automatic apply_row(input string tag, input int idx, input vec_t r);
        logic bad;
        wr_en = r.we; wr_data[0] = r.wd; rd_en = r.re; wrap_rd = r.wr; pop_vec = r.pv;
        @(posedge clk_in);
        #1;
        bad = (rd_valid !== r.ev) || (full !== r.ef) || (empty !== r.ee) ||
              (vec_count !== r.ec);
        if (r.ev) bad = bad || (rd_data !== r.ed) || (rd_last !== r.el);
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s[%0d]: got v=%0b d=%h l=%0b f=%0b e=%0b c=%0d want v=%0b d=%h l=%0b f=%0b e=%0b c=%0d",
                     tag, idx, rd_valid, rd_data, rd_last, full, empty, vec_count,
                     r.ev, r.ed, r.el, r.ef, r.ee, r.ec);
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        // Single vector 0..7, then reads, wrap-around and rewind.
        for (int i = 0; i < 7; i++) tab_a.push_back(row(1, 8'(i), 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tab_a.push_back(row(1, 8'd7, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tab_a.push_back(row(0, 0, 1, 0, 0, 1, 16'h0100, 0, 0, 0, 1));
        tab_a.push_back(row(0, 0, 1, 0, 0, 1, 16'h0302, 0, 0, 0, 1));
        tab_a.push_back(row(0, 0, 1, 0, 0, 1, 16'h0504, 0, 0, 0, 1));
        tab_a.push_back(row(0, 0, 1, 0, 0, 1, 16'h0706, 1, 0, 0, 1));
        tab_a.push_back(row(0, 0, 1, 0, 0, 1, 16'h0100, 0, 0, 0, 1));
        tab_a.push_back(row(0, 0, 1, 0, 0, 1, 16'h0302, 0, 0, 0, 1));
        tab_a.push_back(row(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        tab_a.push_back(row(0, 0, 1, 0, 0, 1, 16'h0100, 0, 0, 0, 1));
        // Fill to full, dropped write, pop and read second vector.
        for (int i = 8; i < 15; i++) tab_a.push_back(row(1, 8'(i), 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tab_a.push_back(row(1, 8'd15, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        tab_a.push_back(row(1, 8'hAA, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        tab_a.push_back(row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tab_a.push_back(row(0, 0, 1, 0, 0, 1, 16'h0908, 0, 0, 0, 1));
        // Commit and pop in the same cycle.
        for (int i = 16; i < 23; i++) tab_a.push_back(row(1, 8'(i), 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tab_a.push_back(row(1, 8'd23, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tab_a.push_back(row(0, 0, 1, 0, 0, 1, 16'h1110, 0, 0, 0, 1));
        tab_a.push_back(row(0, 0, 1, 0, 0, 1, 16'h1312, 0, 0, 0, 1));
        // Empty-side protection.
        tab_a.push_back(row(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tab_a.push_back(row(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tab_a.push_back(row(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tab_a.push_back(row(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 24; i < 31; i++) tab_a.push_back(row(1, 8'(i), 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tab_a.push_back(row(1, 8'd31, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tab_a.push_back(row(0, 0, 1, 0, 0, 1, 16'h1918, 0, 0, 0, 1));
        // Partial vector of 5 bytes, last beat alongside a read.
        for (int i = 32; i < 36; i++) tab_a.push_back(row(1, 8'(i), 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tab_a.push_back(row(1, 8'd36, 1, 0, 0, 1, 16'h1b1a, 0, 0, 0, 1));
        // After mid-vector reset: fresh vector 8..15.
        for (int i = 8; i < 15; i++) tab_b.push_back(row(1, 8'(i), 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tab_b.push_back(row(1, 8'd15, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tab_b.push_back(row(0, 0, 1, 0, 0, 1, 16'h0908, 0, 0, 0, 1));
        tab_b.push_back(row(0, 0, 1, 0, 0, 1, 16'h0b0a, 0, 0, 0, 1));

        // Power-on reset state.
        #12;
        chk("reset_rd_valid", 16'(rd_valid), 16'h0);
        chk("reset_empty", 16'(empty), 16'h1);
        chk("reset_full", 16'(full), 16'h0);
        chk("reset_count", 16'(vec_count), 16'h0);
        chk("reset_rd_data", rd_data, 16'h0);
        @(negedge clk_in);
        rst_in = 1'b1;

        foreach (tab_a[i]) apply_row("tab_a", i, tab_a[i]);

        // Asynchronous reset mid-vector must act before any clock edge.
        wr_en = 1'b0; rd_en = 1'b0; wrap_rd = 1'b0; pop_vec = 1'b0;
        #2;
        rst_in = 1'b0;
        #1;
        chk("midrst_rd_valid", 16'(rd_valid), 16'h0);
        chk("midrst_rd_last", 16'(rd_last), 16'h0);
        chk("midrst_rd_data", rd_data, 16'h0);
        chk("midrst_full", 16'(full), 16'h0);
        chk("midrst_empty", 16'(empty), 16'h1);
        chk("midrst_count", 16'(vec_count), 16'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;

        foreach (tab_b[i]) apply_row("tab_b", i, tab_b[i]);

        wr_en = 1'b0; rd_en = 1'b0; wrap_rd = 1'b0; pop_vec = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vec_stream_buffer.md
# vec_stream_buffer

Multi-vector successor to the single-vector VecFIFO: buffers up to `Depth` complete vectors of `VecElements` bytes between a producer writing `BytesPerWrite` bytes per beat and a consumer such as MVProd reading `BytesPerRead` bytes per beat. The consumer re-reads the head vector any number of times, rewinding with `wrap_rd`, and releases it explicitly with `pop_vec`. A producer can therefore fill vector N+1 while MVProd is still iterating over vector N. Full/empty flags, an occupancy count, and a registered read with a valid flag replace the ad-hoc timing of the old block.

## Interface
- `VecElements`, 8: bytes per vector. Must be a multiple of both `BytesPerWrite` and `BytesPerRead`.
- `BytesPerWrite`, 1: bytes accepted per write beat.
- `BytesPerRead`, 2: bytes returned per read beat.
- `Depth`, 2: number of whole vectors stored, ≥1, need not be a power of 2.
- `clk_in` in 1: the single clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write one chunk.
- `wr_data` in [BytesPerWrite][8]: write chunk. Element 0 is the lowest vector index.
- `rd_en` in 1: read the chunk at the read pointer.
- `rd_data` out [BytesPerRead][8]: registered read chunk.
- `rd_valid` out 1: `rd_data` holds data from an accepted read.
- `rd_last` out 1: the current `rd_data` is the final chunk of its vector. Qualified by `rd_valid`.
- `wrap_rd` in 1: rewind the read chunk pointer to 0 in the head vector.
- `pop_vec` in 1: release the head vector.
- `full` out 1: `vec_count == Depth`.
- `empty` out 1: `vec_count == 0`.
- `vec_count` out $clog2(Depth+1): number of committed vectors.

## Operation
- **Storage.** Depth×VecElements bytes. Write side tracks `wr_vec` and `wr_chunk`; read side tracks `rd_vec` (head) and `rd_chunk`. Vector indices wrap from Depth-1 to 0.
- **Write acceptance.** A write is accepted when `wr_en && !full`. The chunk is stored at `wr_vec`/`wr_chunk`, and `wr_chunk` increments.
- **Write commit.** On the last chunk (`wr_chunk == VecElements/BytesPerWrite-1`), `wr_chunk` returns to 0, `wr_vec` advances, and the vector is committed (`vec_count` +1).
- **Write while full.** `wr_en` while full is dropped silently: no pointer change, no storage change.
- **Partial vectors.** A partially written vector is invisible to the read side and is not counted.
- **Read acceptance.** A read is accepted when `rd_en && !empty && !wrap_rd && !pop_vec`. `rd_data` captures the chunk at `rd_vec`/`rd_chunk`, and `rd_chunk` increments.
- **Read wrap.** After the last chunk, `rd_chunk` wraps to 0 within the same vector. There is no auto-pop.
- **Read outputs.** `rd_valid` is 1 the cycle after an accepted read and 0 otherwise. `rd_data` holds its last value when no read is accepted.
- **`wrap_rd` behaviour.** Sets `rd_chunk` to 0 and keeps the head vector. It is allowed while empty.
- **`pop_vec` behaviour.** Only when `!empty`: `rd_vec` advances, `rd_chunk` is set to 0, and `vec_count` decrements. `pop_vec` while empty is ignored.
- **Priority on the read side.** `pop_vec` > `wrap_rd` > `rd_en`. The lower-priority requests in the same cycle are ignored.
- **Simultaneous commit and pop.** `vec_count` is unchanged, and `full`/`empty` hold their values.
- **Reset.** Asserting `rst_in` low at any time, including mid-vector, immediately does the following:
  - zeroes all pointers and `vec_count`;
  - sets `rd_data` to 0, `rd_valid` to 0, `rd_last` to 0 and `full` to 0;
  - sets `empty` to 1 (because `vec_count` is 0).

  Storage contents are not cleared. Partial writes are discarded.

## Timing
- **Write to readable.** The vector commits at the edge that accepts its last chunk. `empty` falls and `vec_count` rises on that same edge, so an `rd_en` in the following cycle is accepted.
- **Read latency.** One cycle: `rd_en` accepted at edge k gives `rd_data`/`rd_valid`/`rd_last` valid after edge k.
- **Back-to-back reads.** Reads may be issued every cycle.
- **Rewind.** `wrap_rd` takes effect at its edge, so a read in the next cycle returns chunk 0.
- **Pop.** After `pop_vec`, `full` falls at the same edge, so a write in the next cycle is accepted. A write in the same cycle as the pop is still blocked, because `full` was registered before the pop.
- **Flag encoding.** `full`, `empty` and `vec_count` are registered or derived purely from registered state; there is no combinational path from inputs to them.

## Structure
- **Package `vec_buf_pkg`.** Holds:
  - `typedef logic [7:0] byte_t`;
  - a function `chunks(int elems, int per)` returning elems/per;
  - a constant-width helper for pointer sizing.
- **Top-level assertions.** Elaboration-time `$error` checks for divisibility and `Depth` ≥ 1.
- **Sub-module `vec_buf_mem`.** Byte-addressed simple dual-port array with `BytesPerWrite` write lanes and a registered `BytesPerRead`-lane read port. The top level owns pointers, count, flags and priority logic.

## Test plan
All scenarios use VecElements=8, W=1, R=2, Depth=2.
- **Single vector.** Reset, write bytes 0..7 → `empty` falls after the 8th write. 4 reads return {1,0},{3,2},{5,4},{7,6}; `rd_last` is 1 only on the 4th; a 5th read returns {1,0}.
- **Fill to full.** Write 16 bytes (0..15) → `full`=1, `vec_count`=2. A 17th write (0xAA) is dropped. Pop, read → {9,8}, i.e. the second vector is intact.
- **Rewind.** After reading 2 chunks, pulse `wrap_rd` together with `rd_en` → no `rd_valid` that cycle; the next read returns {1,0}.
- **Commit plus pop.** At `vec_count`=1, pop in the same cycle as the last write of the next vector → `vec_count` stays 1, `empty` stays 0; the next read returns the new vector's first chunk.
- **Empty-side protection.** `pop_vec` and `rd_en` while empty → `vec_count` stays 0, `rd_valid` stays 0, pointers unchanged.
- **Reset mid-operation.** Drive `rst_in` low after 5 bytes of a vector → outputs take their reset values immediately. After release, a fresh write of 8..15 reads back {9,8} first.
